// File: rtl/adc_fifo_burst_reader_pkg.sv
// adc_fifo_burst_reader_pkg: shared ADC read-side types and default sizes
package adc_fifo_burst_reader_pkg;
   localparam int ADC_FIFO_RD_W       = 32;
   localparam int ADC_FIFO_RDY_THRESH = 256;
   localparam int ADC_DATA_W          = ADC_FIFO_RD_W;
   localparam int ADC_BURST_LEN       = ADC_FIFO_RDY_THRESH;
   typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_DRAIN, ST_PAD} rd_state_e;
endpackage

// File: rtl/adc_skid_buf2.sv
// adc_skid_buf2: 2-entry valid/ready buffer with occupancy output
module adc_skid_buf2
   import adc_fifo_burst_reader_pkg::*;
#(
   parameter int DATA_W = ADC_DATA_W
) (
   input  logic              adc_fifo_clk_rd,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic [1:0]        occ
);
   logic [DATA_W-1:0] d0, d1;
   logic pop;
   assign out_valid = occ != 2'd0;
   assign out_data  = d0;
   assign pop       = out_valid && out_ready;
   // Head entry d0 always holds the oldest word; d1 takes the overflow entry
   always_ff @(posedge adc_fifo_clk_rd or negedge rst_n) begin
      if (!rst_n) begin
         d0  <= '0;
         d1  <= '0;
         occ <= '0;
      end else begin
         if (pop)
            d0 <= (occ == 2'd2) ? d1 : in_data;
         else if (in_valid && occ == 2'd0)
            d0 <= in_data;
         if (in_valid && (occ == 2'd2 || (occ == 2'd1 && !pop)))
            d1 <= in_data;
         occ <= occ + {1'b0, in_valid} - {1'b0, pop};
      end
   end
endmodule

// File: rtl/adc_fifo_burst_reader.sv
// adc_fifo_burst_reader: reads fixed-length bursts from the ADC FIFO into a framed stream
module adc_fifo_burst_reader
   import adc_fifo_burst_reader_pkg::*;
#(
   parameter int DATA_W    = ADC_DATA_W,
   parameter int BURST_LEN = ADC_BURST_LEN,
   parameter int CNT_W     = 16
) (
   input  logic              adc_fifo_clk_rd,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              fifo_rd_rdy,
   input  logic              fifo_rd_empty,
   input  logic [DATA_W-1:0] fifo_q,
   output logic              fifo_rdreq,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_sop,
   output logic              m_eop,
   output logic              burst_active,
   output logic [CNT_W-1:0]  burst_cnt,
   output logic              underrun_err,
   input  logic              clr_err
);
   localparam logic [CNT_W-1:0] LEN  = CNT_W'(BURST_LEN);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);
   rd_state_e state;
   logic [CNT_W-1:0] reads_issued, words_out;
   logic inflight, buf_valid, buf_pop, pad_valid, fire;
   logic last_read, underrun_set, frame_done;
   logic [DATA_W-1:0] buf_data;
   logic [1:0] occ, occ_eff;
   adc_skid_buf2 #(.DATA_W(DATA_W)) u_skid (
      .adc_fifo_clk_rd(adc_fifo_clk_rd),
      .rst_n          (rst_n),
      .in_valid       (inflight),
      .in_data        (fifo_q),
      .out_valid      (buf_valid),
      .out_data       (buf_data),
      .out_ready      (m_ready),
      .occ            (occ)
   );
   // Occupancy net of this cycle's pop lets a read overlap a drain for full throughput
   assign buf_pop      = buf_valid && m_ready;
   assign occ_eff      = occ - {1'b0, buf_pop};
   assign fifo_rdreq   = state == ST_BURST && fifo_rd_rdy && !fifo_rd_empty &&
                         reads_issued < LEN && (occ_eff + {1'b0, inflight}) < 2'd2;
   assign pad_valid    = state == ST_PAD && !buf_valid && !inflight;
   assign m_valid      = buf_valid || pad_valid;
   assign m_data       = buf_valid ? buf_data : '0;
   assign m_sop        = m_valid && words_out == '0;
   assign m_eop        = m_valid && words_out == LAST;
   assign fire         = m_valid && m_ready;
   assign burst_active = state != ST_IDLE;
   assign last_read    = fifo_rdreq && reads_issued == LAST;
   assign underrun_set = state == ST_BURST && !fifo_rd_rdy;
   assign frame_done   = fire && words_out == LAST && (state == ST_DRAIN || state == ST_PAD);
   // Burst sequencing, word/frame counters and sticky underrun flag
   always_ff @(posedge adc_fifo_clk_rd or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         reads_issued <= '0;
         words_out    <= '0;
         inflight     <= 1'b0;
         burst_cnt    <= '0;
         underrun_err <= 1'b0;
      end else begin
         inflight     <= fifo_rdreq;
         underrun_err <= underrun_set || (underrun_err && !clr_err);
         if (fifo_rdreq)
            reads_issued <= reads_issued + CNT_W'(1);
         if (fire)
            words_out <= words_out + CNT_W'(1);
         if (frame_done)
            burst_cnt <= burst_cnt + CNT_W'(1);
         case (state)
            ST_IDLE:
               if (enable && fifo_rd_rdy) begin
                  state        <= ST_BURST;
                  reads_issued <= '0;
                  words_out    <= '0;
               end
            ST_BURST:
               state <= last_read ? ST_DRAIN : underrun_set ? ST_PAD : ST_BURST;
            default:
               if (frame_done)
                  state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_adc_fifo_burst_reader.sv
// tb_adc_fifo_burst_reader: scoreboard bench with a queue-based FIFO and frame model
module tb_adc_fifo_burst_reader;
   localparam int LEN = 256;
   typedef struct {
      logic [31:0] d;
      bit sop;
      bit eop;
      bit pad;
   } exp_t;
   logic        clk, rst_n, enable, fifo_rd_rdy, fifo_rd_empty, fifo_rdreq;
   logic [31:0] fifo_q, m_data;
   logic        m_valid, m_ready, m_sop, m_eop, burst_active, underrun_err, clr_err;
   logic [15:0] burst_cnt;
   adc_fifo_burst_reader dut (
      .adc_fifo_clk_rd(clk),
      .rst_n          (rst_n),
      .enable         (enable),
      .fifo_rd_rdy    (fifo_rd_rdy),
      .fifo_rd_empty  (fifo_rd_empty),
      .fifo_q         (fifo_q),
      .fifo_rdreq     (fifo_rdreq),
      .m_data         (m_data),
      .m_valid        (m_valid),
      .m_ready        (m_ready),
      .m_sop          (m_sop),
      .m_eop          (m_eop),
      .burst_active   (burst_active),
      .burst_cnt      (burst_cnt),
      .underrun_err   (underrun_err),
      .clr_err        (clr_err)
   );
   logic [31:0] mem[$];
   exp_t        exp_q[$];
   int errors = 0, checks = 0;
   int exp_idx = 0, reads = 0, data_xfers = 0, frames = 0, test_reads = 0, frame_xfers = 0;
   int drop_at = -1, gap = 0, mode = 0, cyc = 0, sop_cyc = 0, eop_cyc = 0;
   bit rd_c = 0, stalled = 0;
   logic [31:0] p_data;
   logic p_sop, p_eop;

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   task automatic push_words(input int n, input bit seq);
      for (int i = 0; i < n; i++) begin
         logic [31:0] w;
         w = seq ? 32'(i) : $urandom();
         mem.push_back(w);
         exp_q.push_back('{w, exp_idx == 0, exp_idx == LEN - 1, 1'b0});
         exp_idx = (exp_idx + 1) % LEN;
      end
   endtask

   task automatic push_pad();
      while (exp_idx != 0) begin
         exp_q.push_back('{32'h0, 1'b0, exp_idx == LEN - 1, 1'b1});
         exp_idx = (exp_idx + 1) % LEN;
      end
   endtask

   task automatic push_extra(input int n);
      for (int i = 0; i < n; i++) mem.push_back($urandom());
   endtask

   task automatic start_test();
      @(posedge clk);
      #2;
      test_reads  = 0;
      frame_xfers = 0;
      drop_at     = -1;
   endtask

   task automatic wait_done(input string name);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || burst_active) && k < 4000) begin
         @(posedge clk);
         k++;
      end
      #2;
      checks++;
      if (k >= 4000) begin
         errors++;
         $display("FAIL %s_timeout got pending=%0d want 0", name, exp_q.size());
      end
   endtask

   task automatic wait_reads(input int n);
      int k;
      k = 0;
      while (test_reads < n && k < 2000) begin
         @(posedge clk);
         k++;
      end
      #2;
      checks++;
      if (test_reads < n) begin
         errors++;
         $display("FAIL wait_reads_timeout got=%0d want=%0d", test_reads, n);
      end
   endtask

   task automatic wait_xfers(input int n);
      int k;
      k = 0;
      while (frame_xfers < n && k < 2000) begin
         @(posedge clk);
         k++;
      end
      #2;
      checks++;
      if (frame_xfers < n) begin
         errors++;
         $display("FAIL wait_xfers_timeout got=%0d want=%0d", frame_xfers, n);
      end
   endtask

   // FIFO model (non-showahead) and m_ready pattern, driven just after each edge
   always begin
      @(negedge clk);
      rd_c = fifo_rdreq;
      if (rst_n && fifo_rd_empty) begin
         checks++;
         if (rd_c) begin
            errors++;
            $display("FAIL rdreq_while_empty got=1 want=0");
         end
      end
      @(posedge clk);
      #1;
      if (rd_c && rst_n) begin
         checks++;
         if (mem.size() == 0) begin
            errors++;
            $display("FAIL fifo_read_underflow got size=0 want >0");
         end else
            fifo_q = mem.pop_front();
         reads++;
         test_reads++;
         if (test_reads == drop_at) fifo_rd_rdy = 0;
      end
      if (gap > 0) gap--;
      fifo_rd_empty = mem.size() == 0 || gap > 0;
      m_ready = mode == 0 ? 1'b1 : mode == 1 ? ~m_ready : mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
   end

   // Stream monitor: scoreboard pop, hold-stability and buffer-depth checks
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n)
         stalled = 0;
      else begin
         checks++;
         if (reads - data_xfers > 2) begin
            errors++;
            $display("FAIL outstanding got=%0d want<=2", reads - data_xfers);
         end
         if (stalled) begin
            checks++;
            if (!m_valid || m_data !== p_data || m_sop !== p_sop || m_eop !== p_eop) begin
               errors++;
               $display("FAIL hold_stable got v=%0b d=%h sop=%0b eop=%0b want v=1 d=%h sop=%0b eop=%0b",
                        m_valid, m_data, m_sop, m_eop, p_data, p_sop, p_eop);
            end
         end
         if (m_valid && m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_word got d=%h want none", m_data);
            end else begin
               e = exp_q.pop_front();
               if (m_data !== e.d || m_sop !== e.sop || m_eop !== e.eop) begin
                  errors++;
                  $display("FAIL stream_word got d=%h sop=%0b eop=%0b want d=%h sop=%0b eop=%0b",
                           m_data, m_sop, m_eop, e.d, e.sop, e.eop);
               end
               if (!e.pad) data_xfers++;
               if (e.sop) begin
                  checks++;
                  sop_cyc = cyc;
                  if (burst_cnt !== 16'(frames)) begin
                     errors++;
                     $display("FAIL burst_cnt_at_sop got=%0d want=%0d", burst_cnt, frames);
                  end
               end
               if (e.eop) begin
                  frames++;
                  eop_cyc = cyc;
               end
            end
            frame_xfers++;
         end
         stalled = m_valid && !m_ready;
         p_data  = m_data;
         p_sop   = m_sop;
         p_eop   = m_eop;
      end
      cyc++;
   end

   initial begin
      rst_n = 0; enable = 1; fifo_rd_rdy = 0; fifo_rd_empty = 1; fifo_q = '0;
      m_ready = 1; clr_err = 0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_m_valid", {31'b0, m_valid}, 0);
      chk("rst_rdreq", {31'b0, fifo_rdreq}, 0);
      chk("rst_burst_active", {31'b0, burst_active}, 0);
      chk("rst_burst_cnt", {16'b0, burst_cnt}, 0);
      chk("rst_underrun", {31'b0, underrun_err}, 0);
      rst_n = 1;

      // full frame 0..255 at full rate, extra words present but never read
      start_test();
      push_words(LEN, 1);
      push_extra(4);
      drop_at = LEN;
      fifo_rd_rdy = 1;
      wait_done("t1");
      chk("t1_reads", test_reads, LEN);
      chk("t1_span", eop_cyc - sop_cyc, LEN - 1);
      chk("t1_burst_cnt", {16'b0, burst_cnt}, 1);
      chk("t1_underrun", {31'b0, underrun_err}, 0);
      repeat (20) @(posedge clk);
      #2;
      chk("t1_no_more_reads", test_reads, LEN);
      mem.delete();

      // same frame with m_ready toggling every cycle
      start_test();
      mode = 1;
      push_words(LEN, 1);
      drop_at = LEN;
      fifo_rd_rdy = 1;
      wait_done("t2");
      chk("t2_burst_cnt", {16'b0, burst_cnt}, 2);
      mode = 0;

      // truncated burst: rdy falls after 100 reads, frame padded with zeros
      start_test();
      push_words(100, 1);
      push_pad();
      drop_at = 100;
      fifo_rd_rdy = 1;
      wait_done("t3");
      chk("t3_reads", test_reads, 100);
      chk("t3_underrun_set", {31'b0, underrun_err}, 1);
      chk("t3_burst_cnt", {16'b0, burst_cnt}, 3);
      @(posedge clk);
      #2 clr_err = 1;
      @(posedge clk);
      #2 clr_err = 0;
      chk("t3_underrun_clr", {31'b0, underrun_err}, 0);

      // FIFO empty for a while mid-burst with rdy still high
      start_test();
      push_words(LEN, 0);
      drop_at = LEN;
      fifo_rd_rdy = 1;
      wait_reads(60);
      gap = 11;
      repeat (6) @(negedge clk);
      chk("t4_gap_m_valid", {31'b0, m_valid}, 0);
      chk("t4_gap_active", {31'b0, burst_active}, 1);
      wait_done("t4");
      chk("t4_underrun", {31'b0, underrun_err}, 0);
      chk("t4_burst_cnt", {16'b0, burst_cnt}, 4);

      // asynchronous reset mid-frame while stalled
      start_test();
      push_words(LEN, 0);
      drop_at = LEN;
      fifo_rd_rdy = 1;
      wait_xfers(50);
      mode = 3;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #2 rst_n = 0;
      #1;
      chk("t5_m_valid", {31'b0, m_valid}, 0);
      chk("t5_m_sop", {31'b0, m_sop}, 0);
      chk("t5_m_eop", {31'b0, m_eop}, 0);
      chk("t5_m_data", m_data, 0);
      chk("t5_rdreq", {31'b0, fifo_rdreq}, 0);
      chk("t5_active", {31'b0, burst_active}, 0);
      chk("t5_burst_cnt", {16'b0, burst_cnt}, 0);
      fifo_rd_rdy = 0;
      mem.delete();
      exp_q.delete();
      exp_idx = 0; reads = 0; data_xfers = 0; frames = 0; mode = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      start_test();
      push_words(LEN, 0);
      drop_at = LEN;
      fifo_rd_rdy = 1;
      wait_done("t5");
      chk("t5_after_cnt", {16'b0, burst_cnt}, 1);

      // enable dropped mid-frame with rdy held high
      start_test();
      push_words(LEN, 0);
      push_extra(8);
      fifo_rd_rdy = 1;
      wait_reads(80);
      enable = 0;
      wait_done("t6");
      chk("t6_active", {31'b0, burst_active}, 0);
      chk("t6_reads", test_reads, LEN);
      repeat (30) @(posedge clk);
      #2;
      chk("t6_no_restart_reads", test_reads, LEN);
      chk("t6_no_restart_active", {31'b0, burst_active}, 0);
      chk("t6_burst_cnt", {16'b0, burst_cnt}, 2);
      fifo_rd_rdy = 0;
      mem.delete();
      @(posedge clk);
      #2 enable = 1;

      // three back-to-back frames with random backpressure
      start_test();
      mode = 2;
      push_words(3 * LEN, 0);
      drop_at = 3 * LEN;
      fifo_rd_rdy = 1;
      wait_done("t7");
      chk("t7_burst_cnt", {16'b0, burst_cnt}, 5);
      chk("t7_underrun", {31'b0, underrun_err}, 0);
      mode = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/adc_fifo_burst_reader.md
Name: adc_fifo_burst_reader

Overview:
Downstream consumer of the ADC input FIFO, clocked in the read domain (adc_fifo_clk_rd).
- Waits for the FIFO-ready flag, then reads exactly BURST_LEN words from the non-showahead FIFO (q valid one cycle after rdreq).
- Emits those words as a framed valid/ready stream (sop/eop) towards the PCI transfer engine.
- A 2-entry skid buffer absorbs the FIFO read latency under backpressure.
- Truncated bursts are padded so every frame is exactly BURST_LEN words.

Parameters:
DATA_W, 32, FIFO read-data and stream width
BURST_LEN, 256, words per frame (>=2)
CNT_W, 16, width of the burst counter

Ports:
adc_fifo_clk_rd  in  1  clock (FIFO read clock)
rst_n  in  1  reset, asynchronous, active-low
enable  in  1  permits starting new bursts
fifo_rd_rdy  in  1  FIFO holds a readable block (level)
fifo_rd_empty  in  1  FIFO empty
fifo_q  in  DATA_W  FIFO read data, valid the cycle after fifo_rdreq
fifo_rdreq  out  1  FIFO read request
m_data  out  DATA_W  stream data
m_valid  out  1  stream valid
m_ready  in  1  stream ready
m_sop  out  1  first word of frame
m_eop  out  1  last word of frame
burst_active  out  1  state != IDLE
burst_cnt  out  CNT_W  completed frames, wraps
underrun_err  out  1  sticky; set on truncated burst
clr_err  in  1  clears underrun_err

Behaviour:
- Reset (asynchronous, any state): state=IDLE, all outputs 0, skid buffer emptied, counters 0, in-flight read discarded.
- Handshake:
  - A word transfers when m_valid && m_ready.
  - m_data, m_sop and m_eop hold stable while m_valid=1 && m_ready=0.
- Credit rule:
  - fifo_rdreq=1 only when all hold: state=BURST, !fifo_rd_empty, reads_issued<BURST_LEN, and (buffer occupancy + in-flight read) < 2.
  - fifo_rdreq is combinational from registered state.
  - fifo_q is written into the buffer on the cycle after fifo_rdreq.
- State machine:
  - IDLE: when enable && fifo_rd_rdy, go to BURST; reads_issued=0, words_out=0.
  - BURST:
    - Issue reads per the credit rule. If fifo_rd_empty with fifo_rd_rdy=1, stall (no error).
    - When reads_issued reaches BURST_LEN, go to DRAIN.
    - If fifo_rd_rdy falls while reads_issued<BURST_LEN: set underrun_err, stop reads, go to PAD.
  - PAD:
    - Drain buffered/in-flight words first.
    - Then emit zero words until words_out=BURST_LEN.
    - On the final accepted word, go to IDLE.
  - DRAIN: on the final accepted word (words_out=BURST_LEN), go to IDLE.
- Counting and framing:
  - burst_cnt increments on every completed frame, including padded frames; it wraps modulo 2^CNT_W.
  - m_sop=1 on the word with words_out=0.
  - m_eop=1 on the word with words_out=BURST_LEN-1.
- Latency: first m_valid asserts 2 cycles after the IDLE->BURST transition (rdreq cycle, then the data cycle).
- Throughput: 1 word/cycle sustained when m_ready=1 and the FIFO is non-empty.
- Back-to-back frames: the IDLE->BURST transition may occur the cycle after the eop handshake.
- enable deasserted mid-burst: the current frame completes normally; no new burst starts.
- Error flag:
  - clr_err clears underrun_err.
  - If clr_err and a new underrun occur in the same cycle, set wins.
- fifo_rd_rdy pulsing again during DRAIN or PAD is ignored until IDLE.

Decomposition:
- Shared ADC package:
  - state enum type (IDLE, BURST, DRAIN, PAD)
  - DATA_W and BURST_LEN defaults, tied to the ADC FIFO read width and the FIFO-ready threshold constants
- Sub-module adc_skid_buf2: 2-entry valid/ready buffer with occupancy output. The parent contains only the FSM and counters.

Test Plan:
- FIFO preloaded with 256 words 0..255, fifo_rd_rdy=1, m_ready=1 -> 256 consecutive words 0..255; sop on 0, eop on 255; burst_cnt=1; no fifo_rdreq after the 256th.
- Same stimulus with m_ready toggling 1/0 every cycle -> no lost or duplicated words; data stable while stalled; at most 2 words buffered (checked via the credit rule).
- fifo_rd_rdy drops after 100 words are read -> words 0..99 then 156 zero words; eop on the 256th word; underrun_err=1; burst_cnt=1. Then clr_err -> underrun_err=0.
- FIFO goes empty for 10 cycles mid-burst with fifo_rd_rdy=1 -> fifo_rdreq=0 and m_valid drops; the frame resumes intact; underrun_err stays 0.
- rst_n asserted at word 50 with m_ready=0 -> all outputs 0 immediately. After release with fifo_rd_rdy=1 -> a fresh frame starting with sop; burst_cnt=0 before it completes.
- enable=0 asserted mid-frame with fifo_rd_rdy held high -> the current frame completes; burst_active=0 afterwards; no further fifo_rdreq.
